// File: rtl/reindeer_fetch_queue_pkg.sv
// Shared widths, FSM encoding and queue entry layout for the fetch queue.
package reindeer_fetch_queue_pkg;

  localparam int XLEN        = 32;
  localparam int PC_BITWIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fq_state_t;

  typedef struct packed {
    logic [PC_BITWIDTH-1:0] pc;
    logic [XLEN-1:0]        ir;
  } fq_entry_t;

endpackage

// File: rtl/reindeer_fetch_queue_fifo.sv
// Circular instruction buffer; a write is visible at the head the next cycle.
// Push and pop together are legal even when full; flush drops contents, clear also zeroes storage.
module reindeer_fetch_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  assign full = (level == (PTR_W+1)'(DEPTH));
  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // When full, the pop frees the head slot in the same edge the write lands in it.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) level <= level + (PTR_W+1)'(1);
      else if (pop && !push) level <= level - (PTR_W+1)'(1);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!reset_n || clear || flush)
                                !(push && full && !pop));

endmodule

// File: rtl/reindeer_fetch_queue.sv
// Fetch queue: issues sequential fetch requests under a credit limit, discards stale returns
// after a redirect, and presents buffered words to decode one cycle after return (stalls on issue_ready).
module reindeer_fetch_queue
  import reindeer_fetch_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     redirect_req,
  input  logic [PC_BITWIDTH-1:0]   redirect_addr,
  output logic                     fetch_init,
  output logic [PC_BITWIDTH-1:0]   start_addr,
  output logic                     fetch_next,
  input  logic                     fetch_enable_in,
  input  logic [XLEN-1:0]          IR_in,
  input  logic [PC_BITWIDTH-1:0]   PC_in,
  output logic                     issue_valid,
  output logic [XLEN-1:0]          issue_IR,
  output logic [PC_BITWIDTH-1:0]   issue_PC,
  input  logic                     issue_ready,
  output logic [$clog2(DEPTH):0]   queue_level
);
  localparam int CNT_W = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 2;

  fq_state_t        state, state_nxt;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic [CNT_W-1:0] discard, discard_nxt;
  logic             fetch_next_nxt;
  logic             issued;
  logic             ret_counted;
  logic             push;
  logic             pop;
  fq_entry_t        push_entry;
  fq_entry_t        head_entry;

  assign issued          = fetch_init | fetch_next;
  assign ret_counted     = fetch_enable_in && (state == ST_RUN) && (outstanding != '0);
  assign pop             = issue_valid & issue_ready;
  assign push_entry.pc   = PC_in;
  assign push_entry.ir   = IR_in;
  assign issue_valid     = (queue_level != '0);
  assign issue_PC        = head_entry.pc;
  assign issue_IR        = head_entry.ir;

  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    fetch_next_nxt  = 1'b0;
    push            = 1'b0;

    if (issued && !ret_counted && (outstanding != '1))
      outstanding_nxt = outstanding + CNT_W'(1);
    else if (!issued && ret_counted)
      outstanding_nxt = outstanding - CNT_W'(1);

    if (redirect_req) begin
      // Everything still in flight after this cycle belongs to the old path.
      state_nxt   = ST_RUN;
      discard_nxt = outstanding_nxt;
    end else if (state == ST_RUN) begin
      if (fetch_enable_in) begin
        if (discard != '0) discard_nxt = discard - CNT_W'(1);
        else               push        = 1'b1;
      end
      fetch_next_nxt = !issued
                    && (int'(queue_level) + int'(outstanding) < DEPTH)
                    && (int'(outstanding) < MAX_OUTSTANDING);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      discard     <= '0;
      fetch_init  <= 1'b0;
      fetch_next  <= 1'b0;
      start_addr  <= '0;
    end else if (sync_reset) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      discard     <= '0;
      fetch_init  <= 1'b0;
      fetch_next  <= 1'b0;
      start_addr  <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      fetch_init  <= redirect_req;
      fetch_next  <= fetch_next_nxt;
      if (redirect_req) start_addr <= redirect_addr;
    end
  end

  reindeer_fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_BITWIDTH + XLEN)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (sync_reset),
    .flush     (redirect_req),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .level     (queue_level)
  );

endmodule

// File: tb/tb_reindeer_fetch_queue.sv
// Directed and randomized bench: a fetch-unit emulator answers requests, a queue-based model predicts outputs.
module tb_reindeer_fetch_queue;
  import reindeer_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset_n, sync_reset, redirect_req, fetch_enable_in, issue_ready;
  logic [31:0] redirect_addr, IR_in, PC_in;
  logic        fetch_init, fetch_next, issue_valid;
  logic [31:0] start_addr, issue_IR, issue_PC;
  logic [2:0]  queue_level;

  always #5 clk = ~clk;

  reindeer_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .redirect_req(redirect_req), .redirect_addr(redirect_addr),
    .fetch_init(fetch_init), .start_addr(start_addr), .fetch_next(fetch_next),
    .fetch_enable_in(fetch_enable_in), .IR_in(IR_in), .PC_in(PC_in),
    .issue_valid(issue_valid), .issue_IR(issue_IR), .issue_PC(issue_PC),
    .issue_ready(issue_ready), .queue_level(queue_level)
  );

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [63:0] m_q[$];
  int          m_outs, m_disc;
  bit          m_run, m_fi, m_fn, m_zero;
  logic [31:0] m_sa;

  // fetch unit emulator
  typedef struct { int due; logic [31:0] pc; logic [31:0] ir; } req_t;
  req_t        pend[$];
  logic [31:0] env_pc;
  int          env_lat, last_due, cyc;

  // scenario observers
  int          n_fn;
  bit          chk_seq, chk_outs, watch_first, ok;
  logic [31:0] exp_seq, first_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [63:0] h;
    chk("fetch_init", fetch_init, m_fi);
    chk("fetch_next", fetch_next, m_fn);
    chk("start_addr", start_addr, m_sa);
    chk("queue_level", queue_level, m_q.size());
    chk("issue_valid", issue_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      h = m_q[0];
      chk("issue_PC", issue_PC, h[63:32]);
      chk("issue_IR", issue_IR, h[31:0]);
    end else if (m_zero) begin
      chk("issue_PC_zero", issue_PC, 0);
      chk("issue_IR_zero", issue_IR, 0);
    end
  endtask

  function automatic bit ret_due();
    return pend.size() != 0 && pend[0].due <= cyc;
  endfunction

  task automatic step(input bit redir, input logic [31:0] raddr, input bit rdy, input bit srst,
                      input bit inj, input logic [31:0] inj_pc, input logic [31:0] inj_ir);
    bit          ret, pop_m, nfn;
    logic [31:0] rpc, rir;
    int          outs_n;
    req_t        r;
    if (fetch_next) n_fn++;
    if (fetch_init) env_pc = start_addr;
    if (fetch_next) env_pc = env_pc + 32'd4;
    if (fetch_init || fetch_next) begin
      r.due = (cyc + env_lat > last_due) ? cyc + env_lat : last_due + 1;
      r.pc  = env_pc;
      r.ir  = $urandom;
      pend.push_back(r);
      last_due = r.due;
    end
    if (chk_outs) chk("outstanding_cap", pend.size() <= MAXO, 1);
    ret = 0; rpc = 0; rir = 0;
    if (inj) begin
      ret = 1; rpc = inj_pc; rir = inj_ir;
    end else if (ret_due()) begin
      r = pend.pop_front();
      ret = 1; rpc = r.pc; rir = r.ir;
    end
    if (m_q.size() != 0 && rdy && !redir && !srst) begin
      if (chk_seq) begin
        chk("stream_seq", issue_PC, exp_seq);
        exp_seq = exp_seq + 32'd4;
      end
      if (watch_first) begin
        chk("first_after_redirect", issue_PC, first_pc);
        watch_first = 0;
      end
    end
    redirect_req = redir; redirect_addr = raddr; issue_ready = rdy; sync_reset = srst;
    fetch_enable_in = ret; PC_in = rpc; IR_in = rir;
    if (srst) begin
      m_q.delete(); m_outs = 0; m_disc = 0; m_run = 0; m_fi = 0; m_fn = 0; m_sa = 0; m_zero = 1;
    end else begin
      pop_m  = m_q.size() != 0 && rdy;
      nfn    = m_run && !redir && !m_fi && !m_fn && (m_q.size() + m_outs < DEPTH) && (m_outs < MAXO);
      outs_n = m_outs + ((m_fi || m_fn) ? 1 : 0) - ((m_run && ret && m_outs > 0) ? 1 : 0);
      if (redir) begin
        m_q.delete(); m_disc = outs_n; m_sa = raddr; m_run = 1;
      end else begin
        if (pop_m) void'(m_q.pop_front());
        if (m_run && ret) begin
          if (m_disc > 0) m_disc--;
          else begin m_q.push_back({rpc, rir}); m_zero = 0; end
        end
      end
      m_fi = redir; m_fn = nfn; m_outs = outs_n;
    end
    @(posedge clk); #1;
    cyc++;
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 0; sync_reset = 0; redirect_req = 0; redirect_addr = 0;
    fetch_enable_in = 0; IR_in = 0; PC_in = 0; issue_ready = 0;
    m_outs = 0; m_disc = 0; m_run = 0; m_fi = 0; m_fn = 0; m_zero = 1; m_sa = 0;
    env_pc = 0; env_lat = 1; last_due = 0; cyc = 0; n_fn = 0;
    chk_seq = 0; chk_outs = 0; watch_first = 0; exp_seq = 0; first_pc = 0;
    #12;
    compare_outputs();
    reset_n = 1;

    // boot with decode stalled: requests every other cycle until four words are held
    step(1, 32'h8000_0000, 0, 0, 0, 0, 0);
    chk("boot_init", fetch_init, 1);
    chk("boot_addr", start_addr, 32'h8000_0000);
    n_fn = 0;
    idle(20, 0);
    chk("boot_fetch_next_count", n_fn, 3);
    chk("boot_full_level", queue_level, 4);

    // push and pop on a full queue
    step(0, 0, 1, 0, 1, 32'h8000_0010, 32'hAAAA_0001);
    chk("full_pp_level", queue_level, 4);
    chk("full_pp_head", issue_PC, 32'h8000_0004);
    step(0, 0, 1, 0, 1, 32'h8000_0014, 32'hAAAA_0002);
    chk("full_pp_level2", queue_level, 4);
    chk("full_pp_head2", issue_PC, 32'h8000_0008);
    env_pc = 32'h8000_0014;

    // streaming with two-cycle return latency
    env_lat = 2; chk_seq = 1; chk_outs = 1; exp_seq = 32'h8000_0008;
    idle(40, 1);
    chk_seq = 0; chk_outs = 0;

    // flush with two requests in flight
    env_lat = 4; ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (m_outs == 2 && !m_fi && !m_fn && !ret_due()) ok = 1;
      else step(0, 0, 1, 0, 0, 0, 0);
    end
    chk("flush_setup", ok, 1);
    step(1, 32'h8000_0100, 1, 0, 0, 0, 0);
    chk("flush_level", queue_level, 0);
    watch_first = 1; first_pc = 32'h8000_0100;
    idle(25, 1);
    chk("flush_first_seen", watch_first, 0);

    // return coincident with redirect
    env_lat = 1; ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (m_outs == 1 && !m_fi && !m_fn && ret_due()) ok = 1;
      else step(0, 0, 1, 0, 0, 0, 0);
    end
    chk("collision_setup", ok, 1);
    step(1, 32'h8000_0100, 1, 0, 0, 0, 0);
    watch_first = 1; first_pc = 32'h8000_0100;
    idle(15, 1);
    chk("collision_first_seen", watch_first, 0);

    // synchronous reset mid-stream
    env_lat = 2;
    idle(6, 1);
    step(0, 0, 1, 1, 0, 0, 0);
    chk("rst_fetch_init", fetch_init, 0);
    chk("rst_fetch_next", fetch_next, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_level", queue_level, 0);
    chk("rst_valid", issue_valid, 0);
    chk("rst_pc", issue_PC, 0);
    chk("rst_ir", issue_IR, 0);
    idle(10, 1);
    chk("rst_returns_ignored", queue_level, 0);
    step(1, 32'h8000_0200, 1, 0, 0, 0, 0);
    watch_first = 1; first_pc = 32'h8000_0200;
    idle(15, 1);
    chk("rst_first_seen", watch_first, 0);

    // randomized traffic
    watch_first = 0;
    for (int i = 0; i < 500; i++) begin
      bit          redir, rdy, srst;
      logic [31:0] a;
      env_lat = $urandom_range(1, 3);
      rdy     = ($urandom_range(0, 3) != 0);
      srst    = ($urandom_range(0, 99) == 0);
      a       = $urandom & 32'hFFFF_FFFC;
      if (!m_run) redir = (pend.size() == 0);
      else        redir = ($urandom_range(0, 29) == 0);
      step(redir, a, rdy, srst, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
